bfly4_stage: RTL and testbench

BFLY4_STAGE -- requirements
Module: bfly4_stage

---
 rtl/bfly4_stage.sv | 143 ++++++++++++++
 tb/tb_bfly4_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bfly4_stage.sv
// Radix-4 butterfly stage: two-cycle pipeline (sums/diffs, then +/-j rotation, scaling and width reduction).
// Backpressure: both stages freeze while out_valid && !out_ready. Optional saturation and ovf flag under `BFLY4_SAT_EN.
module bfly4_stage #(
    parameter int DW    = 16,
    parameter int SCALE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inverse,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x0_re,
    input  logic signed [DW-1:0] x0_im,
    input  logic signed [DW-1:0] x1_re,
    input  logic signed [DW-1:0] x1_im,
    input  logic signed [DW-1:0] x2_re,
    input  logic signed [DW-1:0] x2_im,
    input  logic signed [DW-1:0] x3_re,
    input  logic signed [DW-1:0] x3_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] y0_re,
    output logic signed [DW-1:0] y0_im,
    output logic signed [DW-1:0] y1_re,
    output logic signed [DW-1:0] y1_im,
    output logic signed [DW-1:0] y2_re,
    output logic signed [DW-1:0] y2_im,
    output logic signed [DW-1:0] y3_re,
    output logic signed [DW-1:0] y3_im,
    output logic [15:0]          frame_cnt,
    output logic                 ovf,
    input  logic                 clr_ovf
);

    localparam logic signed [DW+1:0] MAXV = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] MINV = {3'b111, {(DW-1){1'b0}}};

    // Stage A order: s0re, s0im, s1re, s1im, d0re, d0im, d1re, d1im
    logic signed [DW:0]   a_q [8];
    logic signed [DW:0]   a_d [8];
    logic                 a_vld_q, a_inv_q;
    logic                 b_vld_q;
    logic signed [DW-1:0] y_q [8];
    logic signed [DW-1:0] y_d [8];
    logic signed [DW+1:0] r   [8];
    logic signed [DW+1:0] w   [8];
    logic [7:0]           clip;
    logic [15:0]          frame_cnt_q;
    logic                 ovf_q, ovf_d;
    logic                 stall;

    assign stall    = b_vld_q && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        a_d[0] = {x0_re[DW-1], x0_re} + {x2_re[DW-1], x2_re};
        a_d[1] = {x0_im[DW-1], x0_im} + {x2_im[DW-1], x2_im};
        a_d[2] = {x1_re[DW-1], x1_re} + {x3_re[DW-1], x3_re};
        a_d[3] = {x1_im[DW-1], x1_im} + {x3_im[DW-1], x3_im};
        a_d[4] = {x0_re[DW-1], x0_re} - {x2_re[DW-1], x2_re};
        a_d[5] = {x0_im[DW-1], x0_im} - {x2_im[DW-1], x2_im};
        a_d[6] = {x1_re[DW-1], x1_re} - {x3_re[DW-1], x3_re};
        a_d[7] = {x1_im[DW-1], x1_im} - {x3_im[DW-1], x3_im};
    end

    always_comb begin
        for (int i = 0; i < 6; i++) r[i] = {a_q[i][DW], a_q[i]};
        // d1 * (+j) = (-im, re); d1 * (-j) = (im, -re)
        r[6] = a_inv_q ? -{a_q[7][DW], a_q[7]} :  {a_q[7][DW], a_q[7]};
        r[7] = a_inv_q ?  {a_q[6][DW], a_q[6]} : -{a_q[6][DW], a_q[6]};
        for (int i = 0; i < 8; i++) begin
            w[i]    = (SCALE != 0) ? (r[i] >>> 1) : r[i];
            clip[i] = 1'b0;
`ifdef BFLY4_SAT_EN
            if (w[i] > MAXV) begin
                y_d[i]  = MAXV[DW-1:0];
                clip[i] = 1'b1;
            end else if (w[i] < MINV) begin
                y_d[i]  = MINV[DW-1:0];
                clip[i] = 1'b1;
            end else begin
                y_d[i]  = w[i][DW-1:0];
            end
`else
            y_d[i] = w[i][DW-1:0];
`endif
        end
    end

`ifdef BFLY4_SAT_EN
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (!stall && a_vld_q && (|clip)) ovf_d = 1'b1;
    end
`else
    logic unused_bits;
    always_comb begin
        ovf_d       = 1'b0;
        unused_bits = clr_ovf ^ ovf_q ^ (|clip) ^ MAXV[0] ^ MINV[0];
        for (int i = 0; i < 8; i++) unused_bits = unused_bits ^ (^w[i][DW+1:DW]);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_vld_q     <= 1'b0;
            b_vld_q     <= 1'b0;
            a_inv_q     <= 1'b0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                a_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            if (!stall) begin
                a_vld_q <= in_valid;
                b_vld_q <= a_vld_q;
                if (in_valid) begin
                    a_q     <= a_d;
                    a_inv_q <= inverse;
                end
                if (a_vld_q) y_q <= y_d;
            end
            if (b_vld_q && out_ready) frame_cnt_q <= frame_cnt_q + 16'd1;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = b_vld_q;
    assign frame_cnt = frame_cnt_q;
    assign ovf       = ovf_q;
    assign y0_re = y_q[0];
    assign y0_im = y_q[1];
    assign y1_re = y_q[2];
    assign y1_im = y_q[3];
    assign y2_re = y_q[4];
    assign y2_im = y_q[5];
    assign y3_re = y_q[6];
    assign y3_im = y_q[7];

endmodule

// File: tb/tb_bfly4_stage.sv
// Directed bench for bfly4_stage: an unscaled instance and a SCALE=1 instance share all inputs.
module tb_bfly4_stage;

    logic clk = 1'b0;
    logic reset, inverse, in_valid, out_ready, clr_ovf;
    logic signed [15:0] x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im;
    logic in_ready, out_valid, ovf;
    logic signed [15:0] y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im;
    logic [15:0] frame_cnt;
    logic s_in_ready, s_out_valid, s_ovf;
    logic signed [15:0] s_y0_re, s_y0_im, s_y1_re, s_y1_im, s_y2_re, s_y2_im, s_y3_re, s_y3_im;
    logic [15:0] s_frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bfly4_stage #(.DW(16), .SCALE(0)) dut (
        .clk(clk), .reset(reset), .inverse(inverse), .in_valid(in_valid), .in_ready(in_ready),
        .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
        .x2_re(x2_re), .x2_im(x2_im), .x3_re(x3_re), .x3_im(x3_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
        .y2_re(y2_re), .y2_im(y2_im), .y3_re(y3_re), .y3_im(y3_im),
        .frame_cnt(frame_cnt), .ovf(ovf), .clr_ovf(clr_ovf)
    );

    bfly4_stage #(.DW(16), .SCALE(1)) dut_s (
        .clk(clk), .reset(reset), .inverse(inverse), .in_valid(in_valid), .in_ready(s_in_ready),
        .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
        .x2_re(x2_re), .x2_im(x2_im), .x3_re(x3_re), .x3_im(x3_im),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .y0_re(s_y0_re), .y0_im(s_y0_im), .y1_re(s_y1_re), .y1_im(s_y1_im),
        .y2_re(s_y2_re), .y2_im(s_y2_im), .y3_re(s_y3_re), .y3_im(s_y3_im),
        .frame_cnt(s_frame_cnt), .ovf(s_ovf), .clr_ovf(clr_ovf)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic set_x(input int a, b, c, d, e, f, g, h);
        x0_re = 16'(a); x0_im = 16'(b); x1_re = 16'(c); x1_im = 16'(d);
        x2_re = 16'(e); x2_im = 16'(f); x3_re = 16'(g); x3_im = 16'(h);
    endtask

    // Accept one vector, then stop at the negedge where its result is visible.
    task automatic push_one(input logic inv);
        @(negedge clk);
        inverse = inv; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat1_out_valid got=%b exp=0", out_valid); end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lat2_out_valid got=%b exp=1", out_valid); end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 0; out_ready = 1; inverse = 0; clr_ovf = 0; set_x(0,0,0,0,0,0,0,0);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_cmp++;
        if ({y0_re, y1_im, y3_re, frame_cnt} !== 64'd0) begin n_bad++; $display("FAIL rst_y_cnt got=%h exp=0", {y0_re, y1_im, y3_re, frame_cnt}); end
        n_cmp++;
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_inverse();
        set_x(100, 0, 10, 20, 30, 5, 4, 8);
        push_one(1'b1);
        n_cmp++;
        if ({y0_re, y0_im, y1_re, y1_im} !== {16'sd130, 16'sd5, 16'sd14, 16'sd28}) begin
            n_bad++; $display("FAIL inv_y0y1 got=%0d,%0d,%0d,%0d exp=130,5,14,28", y0_re, y0_im, y1_re, y1_im); end
        n_cmp++;
        if ({y2_re, y2_im} !== {16'sd70, -16'sd5}) begin
            n_bad++; $display("FAIL inv_y2 got=%0d,%0d exp=70,-5", y2_re, y2_im); end
        n_cmp++;
        if ({y3_re, y3_im} !== {-16'sd12, 16'sd6}) begin
            n_bad++; $display("FAIL inv_y3 got=%0d,%0d exp=-12,6", y3_re, y3_im); end
        @(negedge clk);
        n_cmp++;
        if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL inv_frame_cnt got=%0d exp=1", frame_cnt); end
    endtask

    task automatic test_forward();
        set_x(100, 0, 10, 20, 30, 5, 4, 8);
        push_one(1'b0);
        n_cmp++;
        if ({y3_re, y3_im} !== {16'sd12, -16'sd6}) begin
            n_bad++; $display("FAIL fwd_y3 got=%0d,%0d exp=12,-6", y3_re, y3_im); end
        n_cmp++;
        if ({y0_re, y0_im, y1_re, y1_im, y2_re, y2_im} !== {16'sd130, 16'sd5, 16'sd14, 16'sd28, 16'sd70, -16'sd5}) begin
            n_bad++; $display("FAIL fwd_y0y2 got=%0d,%0d,%0d,%0d,%0d,%0d exp=130,5,14,28,70,-5",
                              y0_re, y0_im, y1_re, y1_im, y2_re, y2_im); end
    endtask

    task automatic test_scale();
        set_x(101, 0, 0, 0, 0, 0, 0, 0);
        push_one(1'b0);
        n_cmp++;
        if ({s_y0_re, s_y2_re} !== {16'sd50, 16'sd50}) begin
            n_bad++; $display("FAIL scale_pos got=%0d,%0d exp=50,50", s_y0_re, s_y2_re); end
        n_cmp++;
        if ({y0_re, y2_re} !== {16'sd101, 16'sd101}) begin
            n_bad++; $display("FAIL noscale_pos got=%0d,%0d exp=101,101", y0_re, y2_re); end
        set_x(-101, 0, 0, 0, 0, 0, 0, 0);
        push_one(1'b0);
        n_cmp++;
        if ({s_y0_re, s_y2_re} !== {-16'sd51, -16'sd51}) begin
            n_bad++; $display("FAIL scale_neg got=%0d,%0d exp=-51,-51", s_y0_re, s_y2_re); end
    endtask

    task automatic test_overflow();
        logic signed [15:0] exp_y0;
        logic               exp_ovf;
`ifdef BFLY4_SAT_EN
        exp_y0 = 16'sd32767; exp_ovf = 1'b1;
`else
        exp_y0 = -16'sd2;    exp_ovf = 1'b0;
`endif
        set_x(32767, 0, 0, 0, 32767, 0, 0, 0);
        push_one(1'b0);
        n_cmp++;
        if (y2_re !== 16'sd0) begin n_bad++; $display("FAIL ovf_y2 got=%0d exp=0", y2_re); end
        n_cmp++;
        if (y0_re !== exp_y0) begin n_bad++; $display("FAIL ovf_y0 got=%0d exp=%0d", y0_re, exp_y0); end
        n_cmp++;
        if (ovf !== exp_ovf) begin n_bad++; $display("FAIL ovf_flag got=%b exp=%b", ovf, exp_ovf); end
        n_cmp++;
        if (s_y0_re !== 16'sd32767) begin n_bad++; $display("FAIL ovf_scaled_y0 got=%0d exp=32767", s_y0_re); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ovf !== exp_ovf) begin n_bad++; $display("FAIL ovf_sticky got=%b exp=%b", ovf, exp_ovf); end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        n_cmp++;
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
    endtask

    task automatic test_back_to_back();
        int got[$];
        int idx = 0;
        bit saw_stall = 0;
        bit fire_in;
        do_reset();
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            if (idx < 3) begin in_valid = 1'b1; set_x(idx + 1, 0, 0, 0, 0, 0, 0, 0); end
            else in_valid = 1'b0;
            #1;
            if (out_valid && !in_ready) saw_stall = 1;
            if (out_valid && out_ready) got.push_back(int'(y0_re));
            fire_in = in_valid && in_ready;
            @(posedge clk);
            if (fire_in) idx++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (!saw_stall) begin n_bad++; $display("FAIL b2b_in_ready_drop got=never exp=dropped"); end
        n_cmp++;
        if (got.size() != 3) begin n_bad++; $display("FAIL b2b_count got=%0d exp=3", got.size()); end
        else begin
            n_cmp++;
            if (got[0] != 1 || got[1] != 2 || got[2] != 3) begin
                n_bad++; $display("FAIL b2b_order got=%0d,%0d,%0d exp=1,2,3", got[0], got[1], got[2]); end
        end
        n_cmp++;
        if (frame_cnt !== 16'd3) begin n_bad++; $display("FAIL b2b_frame_cnt got=%0d exp=3", frame_cnt); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; set_x(11, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        set_x(22, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
        n_cmp++;
        if ({y0_re, frame_cnt} !== 32'd0) begin n_bad++; $display("FAIL mid_rst_y_cnt got=%0d,%0d exp=0,0", y0_re, frame_cnt); end
        @(negedge clk);
        reset = 1'b0;
        set_x(77, 0, 0, 0, 0, 0, 0, 0);
        push_one(1'b0);
        n_cmp++;
        if (y0_re !== 16'sd77) begin n_bad++; $display("FAIL mid_rst_first got=%0d exp=77", y0_re); end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_no_stale got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_inverse();
        test_forward();
        test_scale();
        test_overflow();
        test_back_to_back();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
